// File: rtl/serial_pkg.sv
// serial_pkg -- definitions shared by the serial transmitter and a future
// receiver.
//   state_t           : line state machine encoding (IDLE, START, DATA, STOP)
//   DEF_DATA_W        : default number of data bits per frame
//   DEF_CLKS_PER_BIT  : default clock cycles per bit on the line
package serial_pkg;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// baud_tick -- bit-period counter for the serial line.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears the count
//   clr  : synchronous clear, holds the count at zero
//   tick : high during the last cycle of each bit period
// The count runs 0 .. CLKS_PER_BIT-1 and wraps to zero on the tick cycle,
// so every bit period is exactly CLKS_PER_BIT cycles long.
module baud_tick
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial line transmitter (start bit, DATA_W data
// bits LSB first, one stop bit; line idles high).
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   tx_data  : word to send
//   tx_valid : tx_data is offered this cycle
//   tx_ready : block can accept a word this cycle (high only in IDLE)
//   tx_out   : registered serial line
//   busy     : a frame is in progress
//   state    : current line state, for debug and checkers
//
// Handshake: a word transfers on a rising edge where tx_valid and tx_ready
// are both high. tx_ready does not depend on tx_valid. Once a word has
// transferred, tx_data and tx_valid are ignored until the frame is over and
// the block is back in IDLE, which lasts at least one cycle between frames.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy,
   output state_t            state
);

   localparam int IDX_W = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  bit_idx;
   logic              tick;
   logic              clr;

   // The counter is held at zero in IDLE and wraps on every tick, and every
   // other state change happens on a tick, so each state is entered with a
   // fresh count.
   assign clr = (state == IDLE);

   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .tick(tick)
   );

   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // The line value for the next bit is loaded into tx_out on the same edge
   // that changes state, so tx_out always lines up with the state and count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx_out  <= 1'b1;
         shreg   <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  shreg   <= tx_data;
                  bit_idx <= '0;
                  tx_out  <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx_out <= shreg[0];
                  shreg  <= shreg >> 1;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_IDX) begin
                     tx_out  <= 1'b1;
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     tx_out  <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               tx_out <= 1'b1;
            end
         endcase
      end
   end

endmodule
